// File: rtl/axis_loopback_tester_if.sv
// AXI-Stream bundle used by the loopback tester on both its generator and checker sides.
interface axis_loopback_tester_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_loopback_tester.sv
// AXI-Stream traffic generator and checker: sends a deterministic burst, compares the
// returned stream against an independent copy of the pattern and reports the verdict.
module axis_loopback_tester #(
    parameter int DATA_W    = 128,
    parameter int LEN_W     = 16,
    parameter int GAP_W     = 4,
    parameter int TIMEOUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [31:0]             seed,
    input  logic [LEN_W-1:0]        len,
    input  logic [GAP_W-1:0]        gap,
    axis_loopback_tester_if.master  m_axis,
    axis_loopback_tester_if.slave   s_axis,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [LEN_W-1:0]        err_count,
    output logic [LEN_W-1:0]        first_err_idx
);

    localparam int          LANES     = DATA_W / 32;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Right-shifting Galois LFSR step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        if (s[0]) begin
            n = (s >> 1) ^ LFSR_POLY;
        end else begin
            n = s >> 1;
        end
        return n;
    endfunction

    // Pattern state for beat 0; an all-zero LFSR seed would lock up, so it becomes 1.
    function automatic logic [DATA_W-1:0] pat_seed(input logic m, input logic [31:0] sd);
        logic [DATA_W-1:0] r;
        r = '0;
        if (m && (sd == 32'd0)) begin
            r[31:0] = 32'd1;
        end else begin
            r[31:0] = sd;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic m, input logic [DATA_W-1:0] st);
        logic [DATA_W-1:0] r;
        r = '0;
        if (m) begin
            r[31:0] = lfsr_step(st[31:0]);
        end else begin
            r = st + DATA_W'(1);
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pat_data(input logic m, input logic [DATA_W-1:0] st);
        logic [DATA_W-1:0] d;
        d = st;
        if (m) begin
            for (int i = 0; i < LANES; i++) begin
                d[32*i +: 32] = st[31:0] ^ 32'(i);
            end
        end else begin
            d = st;
        end
        return d;
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_mode;
    logic [LEN_W-1:0]      r_len;
    logic [GAP_W-1:0]      r_gap;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [DATA_W-1:0]     r_tx_state;
    logic [LEN_W-1:0]      r_tx_cnt;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [DATA_W-1:0]     r_m_tdata;
    logic [DATA_W-1:0]     r_rx_state;
    logic [LEN_W-1:0]      r_rx_cnt;
    logic                  r_s_tready;
    logic [TIMEOUT_W-1:0]  r_wd;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [LEN_W-1:0]      r_err;
    logic [LEN_W-1:0]      r_first;

    logic                  w_start_ok;
    logic                  w_tx_hs;
    logic                  w_rx_hs;
    logic                  w_rx_err;
    logic                  w_rx_final;
    logic                  w_wd_expire;
    logic [DATA_W-1:0]     w_seed_state;
    logic [DATA_W-1:0]     w_tx_nstate;
    logic [DATA_W-1:0]     w_rx_nstate;
    logic [DATA_W-1:0]     w_rx_exp;
    logic [LEN_W-1:0]      w_err_next;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_tx_hs      = r_m_tvalid && m_axis.tready;
    assign w_rx_hs      = r_s_tready && s_axis.tvalid;
    assign w_seed_state = pat_seed(mode, seed);
    assign w_tx_nstate  = pat_next(r_mode, r_tx_state);
    assign w_rx_nstate  = pat_next(r_mode, r_rx_state);
    assign w_rx_exp     = pat_data(r_mode, r_rx_state);
    // Data and framing faults on one beat count as a single error.
    assign w_rx_err     = w_rx_hs && ((s_axis.tdata != w_rx_exp) ||
                                      (s_axis.tlast != (r_rx_cnt == (r_len - LEN_W'(1)))));
    assign w_rx_final   = w_rx_hs && ((r_rx_cnt + LEN_W'(1)) == r_len);
    assign w_wd_expire  = (r_state == S_RUN) && !w_rx_hs && (r_wd == '1);
    assign w_err_next   = (w_rx_err && (r_err != '1)) ? (r_err + LEN_W'(1)) : r_err;

    // Run-control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run-control next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_rx_final || w_wd_expire) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Generator, checker, watchdog and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_len      <= '0;
            r_gap      <= '0;
            r_gap_cnt  <= '0;
            r_tx_state <= '0;
            r_tx_cnt   <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_rx_state <= '0;
            r_rx_cnt   <= '0;
            r_s_tready <= 1'b0;
            r_wd       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= '0;
            r_first    <= '0;
        end else begin
            r_busy     <= (w_state_next == S_RUN);
            r_done     <= (w_state_next == S_DONE);
            r_s_tready <= (w_state_next == S_RUN);
            if (w_start_ok) begin
                r_mode     <= mode;
                r_len      <= len;
                r_gap      <= gap;
                r_gap_cnt  <= '0;
                r_tx_state <= w_seed_state;
                r_tx_cnt   <= '0;
                r_m_tvalid <= (len != '0);
                r_m_tlast  <= (len == LEN_W'(1));
                r_m_tdata  <= pat_data(mode, w_seed_state);
                r_rx_state <= w_seed_state;
                r_rx_cnt   <= '0;
                r_wd       <= '0;
                r_pass     <= (len == '0);
                r_timeout  <= 1'b0;
                r_err      <= '0;
                r_first    <= '0;
            end else if (r_state == S_RUN) begin
                // Generator: a beat is held until accepted, then gap idle cycles follow.
                if (w_state_next != S_RUN) begin
                    r_m_tvalid <= 1'b0;
                end else if (w_tx_hs) begin
                    r_tx_state <= w_tx_nstate;
                    r_tx_cnt   <= r_tx_cnt + LEN_W'(1);
                    if ((r_tx_cnt + LEN_W'(1)) == r_len) begin
                        r_m_tvalid <= 1'b0;
                    end else if (r_gap == '0) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= pat_data(r_mode, w_tx_nstate);
                        r_m_tlast  <= ((r_tx_cnt + LEN_W'(2)) == r_len);
                    end else begin
                        r_m_tvalid <= 1'b0;
                        r_gap_cnt  <= r_gap;
                    end
                end else if (r_gap_cnt != '0) begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= pat_data(r_mode, r_tx_state);
                        r_m_tlast  <= ((r_tx_cnt + LEN_W'(1)) == r_len);
                    end
                end

                // Checker and watchdog.
                if (w_rx_hs) begin
                    r_rx_state <= w_rx_nstate;
                    r_rx_cnt   <= r_rx_cnt + LEN_W'(1);
                    r_wd       <= '0;
                end else begin
                    r_wd <= r_wd + TIMEOUT_W'(1);
                end
                r_err <= w_err_next;
                if (w_rx_err && (r_err == '0)) begin
                    r_first <= r_rx_cnt;
                end
                if (w_wd_expire) begin
                    r_timeout <= 1'b1;
                end
                if (w_state_next == S_DONE) begin
                    r_pass <= !w_wd_expire && (w_err_next == '0);
                end
            end else begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis.tdata   = r_m_tdata;
    assign m_axis.tvalid  = r_m_tvalid;
    assign m_axis.tlast   = r_m_tlast;
    assign s_axis.tready  = r_s_tready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err;
    assign first_err_idx  = r_first;

endmodule

// File: doc/axis_loopback_tester.md
# axis_loopback_tester

Parametrised AXI-Stream traffic generator and checker for self-test of the AES-256-CTR datapath. It drives a programmable-length burst of deterministic plaintext on its master port. It expects the same sequence back on its slave port, for example after an encrypt→decrypt pair with the same key and IV. It reports pass/fail, the error count, the first mismatching beat and a timeout, so bring-up can run on hardware without the file-driven producer/consumer.

## Interface
- DATA_W, 128, stream width in bits; must be a multiple of 32
- LEN_W, 16, width of burst length, beat counters and error counter
- GAP_W, 4, width of inter-beat idle-cycle setting
- TIMEOUT_W, 12, receive watchdog; expires after 2^TIMEOUT_W cycles with no accepted rx beat

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- mode  in  1  0 = incrementing pattern, 1 = LFSR pattern
- seed  in  32  pattern seed, sampled at start
- len  in  LEN_W  beats per burst, sampled at start
- gap  in  GAP_W  idle cycles inserted after each tx handshake, sampled at start
- m_axis_tdata  out  DATA_W  generated data
- m_axis_tvalid  out  1  generated beat valid
- m_axis_tlast  out  1  high on beat len-1
- m_axis_tready  in  1  downstream ready
- s_axis_tdata  in  DATA_W  returned data
- s_axis_tvalid  in  1  returned beat valid
- s_axis_tlast  in  1  returned last
- s_axis_tready  out  1  high only while receiving
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  run completed, zero errors, no timeout
- timeout  out  1  watchdog expired during last run
- err_count  out  LEN_W  mismatching beats, saturating
- first_err_idx  out  LEN_W  beat index of first mismatch; meaningful when err_count ≠ 0

## Operation
- FSM: IDLE → RUN on start; RUN → DONE when rx beat count = len, or when the watchdog expires; DONE → IDLE after exactly one cycle.
- start with len = 0: RUN is skipped, DONE is entered directly, pass = 1.
- start while in RUN or DONE is ignored.
- Results (pass, timeout, err_count, first_err_idx) are cleared on entering RUN and held after DONE until the next start.
- Pattern, beat k (0-based):
  - Mode 0: tdata = zero-extend(seed) + k, mod 2^DATA_W.
  - Mode 1: a 32-bit Galois LFSR with polynomial 0x80200003 is loaded with seed, or with 1 if seed = 0. Beat 0 uses the loaded state, and the LFSR advances one step per beat. Lane i (bits 32i+31:32i) = lfsr ^ i.
- Tx and rx each run an independent copy of the pattern engine; rx advances only on an s-side handshake.
- Tx engine:
  - Presents beat k, holds it until handshake, then stays low for `gap` cycles.
  - Stops after beat len-1.
- Rx engine:
  - s_axis_tready = 1 in RUN while rx count < len.
  - A beat is an error if tdata ≠ expected, or tlast ≠ (k == len-1). A beat with both faults counts once.
  - err_count saturates at all-ones.
  - first_err_idx is latched on the first error only.
- Watchdog:
  - Reloads on entering RUN and on every rx handshake.
  - On expiry: timeout = 1, pass = 0, DONE.

## Timing
- Reset values: all outputs 0; FSM = IDLE; LFSRs and counters cleared.
- Reset mid-run aborts immediately, with no done pulse; tvalid drops on the cycle after rst.
- start sampled in cycle 0 → busy = 1 and m_axis_tvalid = 1 with beat 0 in cycle 1.
- With gap = 0 and m_axis_tready held high, one beat is sent per cycle.
- A handshake in cycle n with gap g gives the next tvalid in cycle n+1+g.
- AXI rule: while tvalid = 1 and tready = 0, tdata and tlast are held stable and tvalid is not withdrawn.
- The last rx handshake in cycle n gives done = 1 and busy = 0 in cycle n+1; pass and err_count are final in cycle n+1.
- Same-cycle tx and rx handshakes are both legal, including during a combinational loopback.
- Rx beats arriving in IDLE or DONE are not accepted (tready = 0).

## Test plan
- **Direct loopback, incrementing:** mode 0, seed 0, len 4, gap 0, DATA_W 128, start at cycle 0 → tdata 0,1,2,3 in cycles 1–4; tlast only in cycle 4; done in cycle 5; pass = 1; err_count = 0.
- **LFSR with gap:** mode 1, seed 0xACE12B7F, len 3, gap 2 → tvalid pattern 1,0,0,1,0,0,1 from cycle 1; lane 1 of beat 0 = 0xACE12B7E; pass = 1.
- **Data corruption:** len 5; loopback flips bit 0 of beat 2 → err_count = 1, first_err_idx = 2, pass = 0, timeout = 0.
- **Framing error:** len 4; loopback forces tlast on beat 1 and clears it on beat 3 → err_count = 2, first_err_idx = 1, pass = 0.
- **Stalled sink:** TIMEOUT_W = 4, m_axis_tready held 0 → beat 0 held stable; done pulses 16 cycles after entering RUN; timeout = 1, pass = 0.
- **Control corner cases:**
  - A second start mid-run is ignored.
  - rst asserted mid-run gives all outputs 0 next cycle with no done pulse.
  - len = 0 gives done in cycle 1 with pass = 1 and no tvalid.
